// File: rtl/spike_batch_serializer.sv
// Spike batch serializer: captures one batch of spike indices and streams them
// one index per beat over a valid/ready interface, then pulses batch_done.
module spike_batch_serializer #(
  parameter int MAX_SPIKE = 128,
  parameter int IDX_W     = 14,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       batch_valid,
  output logic                       batch_ready,
  input  logic [CNT_W-1:0]           batch_num,
  input  logic [IDX_W*MAX_SPIKE-1:0] batch_index_flat,
  output logic                       spk_valid,
  input  logic                       spk_ready,
  output logic [IDX_W-1:0]           spk_index,
  output logic                       spk_last,
  output logic                       batch_done,
  output logic                       err_overflow
);

  localparam int AW = (MAX_SPIKE > 1) ? $clog2(MAX_SPIKE) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   ptr_r, ptr_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [IDX_W-1:0]   buf_r [MAX_SPIKE];
  logic               load_s;
  logic               ovf_s;

  logic               batch_ready_r, batch_ready_s;
  logic               spk_valid_r, spk_valid_s;
  logic [IDX_W-1:0]   spk_index_r, spk_index_s;
  logic               spk_last_r, spk_last_s;
  logic               batch_done_r, batch_done_s;
  logic               err_overflow_r, err_overflow_s;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
    if (n > CNT_W'(MAX_SPIKE)) begin
      return CNT_W'(MAX_SPIKE);
    end else begin
      return n;
    end
  endfunction

  // Next-state, pointer and capture control
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    ovf_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (batch_valid && batch_ready_r) begin
          load_s  = 1'b1;
          cnt_s   = clamp_count(batch_num);
          ptr_s   = {CNT_W{1'b0}};
          ovf_s   = (batch_num > CNT_W'(MAX_SPIKE));
          state_s = (cnt_s == {CNT_W{1'b0}}) ? DONE : STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        // The pointer stays on the last entry when the batch ends, so it never reaches cnt.
        if (spk_ready && spk_last_r) begin
          state_s = DONE;
        end else if (spk_ready) begin
          ptr_s   = ptr_r + CNT_W'(1);
          state_s = STREAM;
        end else begin
          state_s = STREAM;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    batch_ready_s  = (state_s == IDLE);
    spk_valid_s    = (state_s == STREAM);
    batch_done_s   = (state_s == DONE);
    err_overflow_s = ovf_s;
    spk_index_s    = {IDX_W{1'b0}};
    spk_last_s     = 1'b0;
    if (state_s == STREAM) begin
      if (load_s) begin
        spk_index_s = batch_index_flat[IDX_W-1:0];
      end else begin
        spk_index_s = buf_r[ptr_s[AW-1:0]];
      end
      spk_last_s = (ptr_s == (cnt_s - CNT_W'(1)));
    end else begin
      spk_index_s = {IDX_W{1'b0}};
      spk_last_s  = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      ptr_r          <= {CNT_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      batch_ready_r  <= 1'b1;
      spk_valid_r    <= 1'b0;
      spk_index_r    <= {IDX_W{1'b0}};
      spk_last_r     <= 1'b0;
      batch_done_r   <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      ptr_r          <= ptr_s;
      cnt_r          <= cnt_s;
      batch_ready_r  <= batch_ready_s;
      spk_valid_r    <= spk_valid_s;
      spk_index_r    <= spk_index_s;
      spk_last_r     <= spk_last_s;
      batch_done_r   <= batch_done_s;
      err_overflow_r <= err_overflow_s;
    end
  end

  // Batch buffer; entries at or above cnt are captured but never emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_SPIKE; i++) begin
        buf_r[i] <= {IDX_W{1'b0}};
      end
    end else if (load_s) begin
      for (int i = 0; i < MAX_SPIKE; i++) begin
        buf_r[i] <= batch_index_flat[i*IDX_W +: IDX_W];
      end
    end else begin
      for (int i = 0; i < MAX_SPIKE; i++) begin
        buf_r[i] <= buf_r[i];
      end
    end
  end

  assign batch_ready  = batch_ready_r;
  assign spk_valid    = spk_valid_r;
  assign spk_index    = spk_index_r;
  assign spk_last     = spk_last_r;
  assign batch_done   = batch_done_r;
  assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_spike_batch_serializer.sv
// Scoreboard bench for spike_batch_serializer: directed and random batches,
// expected beats queued at issue time and checked by an independent monitor.
module tb_spike_batch_serializer;

  localparam int MAX = 128;
  localparam int IW  = 14;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              batch_valid = 1'b0;
  logic              batch_ready;
  logic [CW-1:0]     batch_num = '0;
  logic [IW*MAX-1:0] batch_index_flat = '0;
  logic              spk_valid;
  logic              spk_ready = 1'b0;
  logic [IW-1:0]     spk_index;
  logic              spk_last;
  logic              batch_done;
  logic              err_overflow;

  spike_batch_serializer #(.MAX_SPIKE(MAX), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .batch_valid(batch_valid), .batch_ready(batch_ready),
    .batch_num(batch_num), .batch_index_flat(batch_index_flat),
    .spk_valid(spk_valid), .spk_ready(spk_ready),
    .spk_index(spk_index), .spk_last(spk_last),
    .batch_done(batch_done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int last; } beat_t;
  beat_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;
  int pop_cnt = 0;
  int done_cyc = 0;
  int idx_a [MAX];
  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability
  initial begin
    int stalled, held_idx, held_last;
    beat_t b;
    stalled = 0; held_idx = 0; held_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (stalled != 0) begin
          chk("stall_valid", int'(spk_valid), 1);
          chk("stall_index", int'(spk_index), held_idx);
          chk("stall_last", int'(spk_last), held_last);
        end
        if (spk_valid) begin
          chk("ready_low_while_streaming", int'(batch_ready), 0);
          if (spk_ready) begin
            stalled = 0;
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", int'(spk_index), -1);
            end else begin
              b = exp_q.pop_front();
              chk("beat_index", int'(spk_index), b.idx);
              chk("beat_last", int'(spk_last), b.last);
              pop_cnt++;
            end
          end else begin
            stalled = 1;
            held_idx = int'(spk_index);
            held_last = int'(spk_last);
          end
        end else begin
          stalled = 0;
        end
        if (batch_done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_no_valid", int'(spk_valid), 0);
          chk("done_ready_low", int'(batch_ready), 0);
        end
        if (err_overflow) ovf_cnt++;
      end
    end
  end

  task automatic load_flat(input int n);
    batch_num = n[CW-1:0];
    for (int i = 0; i < MAX; i++) batch_index_flat[i*IW +: IW] = idx_a[i][IW-1:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX; i++) idx_a[i] = int'($urandom_range(0, 16383));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_batch_ready"}, int'(batch_ready), 1);
    chk({tag, "_spk_valid"}, int'(spk_valid), 0);
    chk({tag, "_spk_index"}, int'(spk_index), 0);
    chk({tag, "_spk_last"}, int'(spk_last), 0);
    chk({tag, "_batch_done"}, int'(batch_done), 0);
    chk({tag, "_err_overflow"}, int'(err_overflow), 0);
  endtask

  // mode 0: spk_ready always 1, 1: random, 2: fixed stall pattern then 1
  task automatic run_batch(input int n, input int mode);
    int k, d0, o0, acc, pi;
    k = (n > MAX) ? MAX : n;
    for (int t = 0; t < 50 && !batch_ready; t++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_batch", int'(batch_ready), 1);
    load_flat(n);
    for (int i = 0; i < k; i++) exp_q.push_back('{idx_a[i], (i == k - 1) ? 1 : 0});
    d0 = done_cnt;
    o0 = ovf_cnt;
    batch_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    batch_valid = 1'b0;
    batch_num = CW'($urandom_range(0, 255));
    chk("ready_low_after_accept", int'(batch_ready), 0);
    // Offsets below count from the cycle right after the accepting edge (offset 0).
    if (mode == 0) chk("first_beat_latency", int'(spk_valid), (k > 0) ? 1 : 0);
    pi = 0;
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      case (mode)
        0:       spk_ready = 1'b1;
        1:       spk_ready = 1'($urandom_range(0, 1));
        default: spk_ready = (pi < 7) ? 1'(pat[pi]) : 1'b1;
      endcase
      pi++;
      @(posedge clk); #1;
    end
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("overflow_pulses", ovf_cnt - o0, (n > MAX) ? 1 : 0);
    if (mode == 0) chk("done_latency", done_cyc - acc, k);
    chk("ready_returns", int'(batch_ready), 1);
    chk("done_one_cycle", int'(batch_done), 0);
    exp_q.delete();
  endtask

  initial begin
    int d0, p0, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_random();
    idx_a[0] = 5; idx_a[1] = 9; idx_a[2] = 16383;
    run_batch(3, 0);

    fill_random();
    run_batch(0, 0);

    fill_random();
    run_batch(4, 2);

    fill_random();
    run_batch(200, 0);

    fill_random();
    run_batch(128, 0);

    // Reset while streaming a 10-spike batch, after two beats have gone out
    fill_random();
    load_flat(10);
    for (int i = 0; i < 10; i++) exp_q.push_back('{idx_a[i], (i == 9) ? 1 : 0});
    d0 = done_cnt;
    p0 = pop_cnt;
    spk_ready = 1'b1;
    batch_valid = 1'b1;
    @(posedge clk); #1;
    batch_valid = 1'b0;
    for (int c = 0; c < 100 && pop_cnt < p0 + 2; c++) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    chk("beats_before_reset", pop_cnt - p0, 2);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - d0, 0);
    fill_random();
    run_batch(2, 0);

    for (int r = 0; r < 10; r++) begin
      fill_random();
      n = int'($urandom_range(0, 140));
      run_batch(n, int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
